// File: rtl/target_number_gen_if.sv
// target_number_gen_if: round request (new_req, Max_digit, round, fixed_mode) from game FSM and BCD target result (target_digits, target_valid, busy) back
interface target_number_gen_if #(
  parameter int N_DIGITS = 3,
  parameter int MW = $clog2(N_DIGITS + 1)
);
  logic new_req;
  logic [MW-1:0] Max_digit;
  logic [2:0] round;
  logic fixed_mode;
  logic [4*N_DIGITS-1:0] target_digits;
  logic target_valid;
  logic busy;
  modport master (output new_req, Max_digit, round, fixed_mode, input target_digits, target_valid, busy);
  modport slave (input new_req, Max_digit, round, fixed_mode, output target_digits, target_valid, busy);
endinterface

// File: rtl/target_number_gen.sv
// target_number_gen: BCD target generator (LFSR rejection sampling or legacy table); ports Clk, Reset_n (async low) and bus (slave: request in, target/valid/busy out)
module target_number_gen #(
  parameter int N_DIGITS = 3,
  parameter int LFSR_W = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1,
  parameter int MW = $clog2(N_DIGITS + 1)
) (
  input logic Clk,
  input logic Reset_n,
  target_number_gen_if.slave bus
);
  localparam int D = 4 * N_DIGITS;
  localparam logic [LFSR_W-1:0] SEED_OK = (SEED == '0) ? LFSR_W'(1) : SEED;
  typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;
  state_t state, state_n;
  logic [LFSR_W-1:0] lfsr;
  logic [MW-1:0] m, idx, m_in;
  logic [D-1:0] digits, fixed_val;
  logic [3:0] cand;
  logic accept, take, last;
  function automatic logic [11:0] table_val(logic [MW-1:0] mm, logic [2:0] r);
    case (int'(mm) * 8 + int'(r))
      9: table_val = 12'h002;
      10: table_val = 12'h008;
      11: table_val = 12'h003;
      17: table_val = 12'h057;
      18: table_val = 12'h096;
      19: table_val = 12'h021;
      25: table_val = 12'h123;
      26: table_val = 12'h000;
      27: table_val = 12'h999;
      default: table_val = 12'h000;
    endcase
  endfunction
  always_comb begin
    m_in = (bus.Max_digit == '0) ? MW'(1) : (int'(bus.Max_digit) > N_DIGITS) ? MW'(N_DIGITS) : bus.Max_digit;
    cand = lfsr[3:0];
    accept = bus.new_req && state != GEN;
    take = state == GEN && cand <= 4'd9;
    last = take && idx + MW'(1) == m;
    fixed_val = D'(table_val(m_in, bus.round));
    state_n = accept ? (bus.fixed_mode ? DONE : GEN) : last ? DONE : state;
  end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      lfsr <= SEED_OK;
      digits <= '0;
      idx <= '0;
      m <= '0;
    end else begin
      lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : '0);
      if (accept) begin
        m <= m_in;
        idx <= '0;
        digits <= bus.fixed_mode ? fixed_val : '0;
      end else if (take) begin
        digits[4*int'(idx) +: 4] <= cand;
        idx <= idx + MW'(1);
      end
    end
  assign bus.target_digits = digits;
  assign bus.target_valid = state == DONE;
  assign bus.busy = state == GEN;
endmodule

// File: tb/tb_target_number_gen.sv
// tb_target_number_gen: randomized and directed checks of target_number_gen (N_DIGITS=3 and 2) against a behavioural LFSR/table model
module tb_target_number_gen;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [15:0] TAPS = 16'hB400;
  logic Clk = 0;
  logic Reset_n = 0;
  int errors = 0;
  int checks = 0;
  int tbl [3][3] = '{'{2, 8, 3}, '{57, 96, 21}, '{123, 0, 999}};
  logic [15:0] mlfsr;
  always #5 Clk = ~Clk;
  target_number_gen_if #(.N_DIGITS(3)) bus3();
  target_number_gen_if #(.N_DIGITS(2)) bus2();
  assign bus2.Max_digit = bus3.Max_digit;
  assign bus2.round = bus3.round;
  assign bus2.fixed_mode = bus3.fixed_mode;
  target_number_gen #(.N_DIGITS(3)) dut3 (.Clk(Clk), .Reset_n(Reset_n), .bus(bus3));
  target_number_gen #(.N_DIGITS(2)) dut2 (.Clk(Clk), .Reset_n(Reset_n), .bus(bus2));
  function automatic logic [15:0] step(logic [15:0] x);
    return (x >> 1) ^ (x[0] ? TAPS : 16'h0);
  endfunction
  always @(posedge Clk or negedge Reset_n) mlfsr <= !Reset_n ? SEED : step(mlfsr);
  function automatic void predict(int n, int md, int rnd, bit fm, logic [15:0] l, output logic [11:0] tgt, output int edges);
    int m, v, got;
    logic [15:0] x;
    m = md == 0 ? 1 : (md > n ? n : md);
    tgt = '0;
    edges = 1;
    if (fm) begin
      v = (rnd >= 1 && rnd <= 3) ? tbl[m-1][rnd-1] : 0;
      for (int k = 0; k < n && k < 3; k++) begin
        tgt[4*k +: 4] = 4'((v / (10 ** k)) % 10);
      end
    end else begin
      got = 0;
      x = step(l);
      while (got < m) begin
        if (x[3:0] <= 4'd9) begin
          tgt[4*got +: 4] = x[3:0];
          got++;
        end
        x = step(x);
        edges++;
      end
    end
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run(int md, int rnd, bit fm, bit dbl);
    logic [11:0] t3, t2;
    int e3, e2, l3, l2;
    l3 = 0;
    l2 = 0;
    @(negedge Clk);
    bus3.Max_digit = 2'(md);
    bus3.round = 3'(rnd);
    bus3.fixed_mode = fm;
    bus3.new_req = 1;
    bus2.new_req = 1;
    predict(3, md, rnd, fm, mlfsr, t3, e3);
    predict(2, md, rnd, fm, mlfsr, t2, e2);
    for (int e = 1; e <= 64 && (l3 == 0 || l2 == 0); e++) begin
      @(negedge Clk);
      bus3.new_req = dbl && !fm && (e % 2 == 1) && e < e3;
      bus2.new_req = 0;
      bus3.Max_digit = 2'($urandom);
      bus3.round = 3'($urandom);
      bus3.fixed_mode = 1'($urandom);
      if (!fm && e < e3) begin
        chk("busy_gen", 32'(bus3.busy), 1);
        chk("valid_gen", 32'(bus3.target_valid), 0);
      end
      if (l3 == 0 && bus3.target_valid) l3 = e;
      if (l2 == 0 && bus2.target_valid) l2 = e;
    end
    bus3.new_req = 0;
    chk("latency3", l3, e3);
    chk("target3", 32'(bus3.target_digits), 32'(t3));
    chk("busy3_done", 32'(bus3.busy), 0);
    chk("latency2", l2, e2);
    chk("target2", 32'(bus2.target_digits), 32'(t2[7:0]));
  endtask
  initial begin
    int f;
    logic [15:0] x;
    bus3.new_req = 0;
    bus2.new_req = 0;
    bus3.Max_digit = 0;
    bus3.round = 0;
    bus3.fixed_mode = 0;
    repeat (2) @(negedge Clk);
    chk("rst_target3", 32'(bus3.target_digits), 0);
    chk("rst_valid3", 32'(bus3.target_valid), 0);
    chk("rst_busy3", 32'(bus3.busy), 0);
    chk("rst_target2", 32'(bus2.target_digits), 0);
    chk("rst_valid2", 32'(bus2.target_valid), 0);
    chk("rst_busy2", 32'(bus2.busy), 0);
    Reset_n = 1;
    run(2, 2, 1, 0);
    chk("tbl_2_2", 32'(bus3.target_digits), 32'h096);
    chk("tbl_valid", 32'(bus3.target_valid), 1);
    run(3, 3, 1, 0);
    chk("tbl_3_3", 32'(bus3.target_digits), 32'h999);
    run(1, 0, 1, 0);
    chk("tbl_1_0", 32'(bus3.target_digits), 0);
    chk("tbl_1_0_valid", 32'(bus3.target_valid), 1);
    run(3, 1, 0, 0);
    run(0, 5, 0, 0);
    chk("md0_upper", 32'(bus3.target_digits[11:4]), 0);
    run(3, 2, 0, 1);
    @(negedge Clk);
    bus3.Max_digit = 2'd3;
    bus3.fixed_mode = 0;
    bus3.new_req = 1;
    x = step(mlfsr);
    f = 2;
    while (x[3:0] > 4'd9) begin
      x = step(x);
      f++;
    end
    @(negedge Clk);
    bus3.new_req = 0;
    repeat (f - 1) @(negedge Clk);
    chk("busy_before_rst", 32'(bus3.busy), 1);
    #2 Reset_n = 0;
    #1;
    chk("midrst_target", 32'(bus3.target_digits), 0);
    chk("midrst_valid", 32'(bus3.target_valid), 0);
    chk("midrst_busy", 32'(bus3.busy), 0);
    @(negedge Clk);
    Reset_n = 1;
    run(3, 1, 0, 0);
    repeat (16) begin
      repeat ($urandom_range(0, 3)) @(negedge Clk);
      run(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), 1'($urandom), 1'($urandom));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
